// File: rtl/unique0_csr.sv
// Machine-mode CSR file: satp, mstatus, mtvec, mscratch, mepc, mcause, mtval and the
// cycle/instret counters, plus trap/ERET redirection for the writeback stage.
module unique0_csr (
  input  logic        clk_core,
  input  logic        reset_n,
  input  logic [11:0] mem1_csr_addr,
  input  logic [1:0]  mem1_csr_write,
  input  logic [31:0] mem1_csr_din,
  output logic        csr_error,
  output logic        csr_flush,
  output logic [31:0] csr_dout,
  input  logic        wb_valid,
  input  logic        wb_stall,
  input  logic        wb_exc,
  input  logic [3:0]  wb_exc_cause,
  input  logic        wb_flush,
  input  logic [29:0] wb_pc,
  input  logic [31:0] wb_data,
  output logic        csr_kill,
  output logic        csr_fe_inhibit,
  output logic        csr_setpc,
  output logic [29:0] csr_newpc,
  output logic [31:0] csr_satp
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    C_IALIGN   = 4'd0,
    C_IFAULT   = 4'd1,
    C_IILLEGAL = 4'd2,
    C_EBREAK   = 4'd3,
    C_LALIGN   = 4'd4,
    C_LFAULT   = 4'd5,
    C_SALIGN   = 4'd6,
    C_SFAULT   = 4'd7,
    C_UCALL    = 4'd8,
    C_SCALL    = 4'd9,
    C_ERET     = 4'd10,
    C_MCALL    = 4'd11,
    C_IPFAULT  = 4'd12,
    C_LPFAULT  = 4'd13,
    C_SPFAULT  = 4'd15
  } cause_t;

  localparam logic [11:0] A_SATP     = 12'h180;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;

  logic [31:0] satp;
  logic        mie;
  logic        mpie;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [31:0] mscratch;
  logic [29:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] cycle;
  logic [63:0] instret;

  logic        wen;
  logic        unimp;
  logic [31:0] wdata;
  logic        trap;
  logic        eret;
  logic [31:0] trap_tval;
  cause_t      cause;
  op_t         op;

  assign op    = op_t'(mem1_csr_write);
  assign cause = cause_t'(wb_exc_cause);
  assign wen   = (op != OP_NONE);
  assign trap  = wb_exc & (cause != C_ERET);
  assign eret  = wb_exc & (cause == C_ERET);

  always_comb begin
    unimp    = 1'b0;
    csr_dout = '0;
    case (mem1_csr_addr)
      A_SATP:          csr_dout = satp;
      A_MSTATUS:       csr_dout = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
      A_MTVEC:         csr_dout = {mtvec_base, 1'b0, mtvec_mode};
      A_MSCRATCH:      csr_dout = mscratch;
      A_MEPC:          csr_dout = {mepc, 2'b00};
      A_MCAUSE:        csr_dout = mcause;
      A_MTVAL:         csr_dout = mtval;
      12'hC00, 12'hC01: csr_dout = cycle[31:0];
      12'hC02:         csr_dout = instret[31:0];
      12'hC80, 12'hC81: csr_dout = cycle[63:32];
      12'hC82:         csr_dout = instret[63:32];
      default:         unimp = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OP_SET:   wdata = csr_dout | mem1_csr_din;
      OP_CLEAR: wdata = csr_dout & ~mem1_csr_din;
      default:  wdata = mem1_csr_din;
    endcase
  end

  always_comb begin
    case (cause)
      C_IALIGN, C_IFAULT, C_IPFAULT, C_EBREAK:
        trap_tval = {wb_pc, 2'b00};
      C_IILLEGAL, C_LALIGN, C_LFAULT, C_SALIGN, C_SFAULT, C_LPFAULT, C_SPFAULT:
        trap_tval = wb_data;
      default:
        trap_tval = '0;
    endcase
  end

  assign csr_error      = unimp | (wen & mem1_csr_addr[11] & mem1_csr_addr[10]);
  assign csr_flush      = wen & (mem1_csr_addr == A_SATP);
  assign csr_satp       = satp;
  assign csr_kill       = wb_exc | (wb_valid & wb_flush);
  assign csr_fe_inhibit = wb_stall;
  assign csr_setpc      = wb_exc | wb_stall;
  assign csr_newpc      = trap ? mtvec_base : (eret ? mepc : wb_pc);

  // Each CSR resolves software write vs. trap/ERET on its own, so a write to one
  // register never suppresses the trap update of another.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      satp       <= '0;
      mie        <= 1'b0;
      mpie       <= 1'b0;
      mtvec_base <= '0;
      mtvec_mode <= 1'b0;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
      cycle      <= '0;
      instret    <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (wb_valid && !wb_stall)
        instret <= instret + 64'd1;

      if (wen && mem1_csr_addr == A_SATP)
        satp <= wdata;

      if (wen && mem1_csr_addr == A_MSTATUS) begin
        mie  <= wdata[3];
        mpie <= wdata[7];
      end else if (trap) begin
        mie  <= 1'b0;
        mpie <= mie;
      end else if (eret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end

      if (wen && mem1_csr_addr == A_MTVEC) begin
        mtvec_base <= wdata[31:2];
        mtvec_mode <= wdata[0];
      end

      if (wen && mem1_csr_addr == A_MSCRATCH)
        mscratch <= wdata;

      if (wen && mem1_csr_addr == A_MEPC)
        mepc <= wdata[31:2];
      else if (trap)
        mepc <= wb_pc;

      if (wen && mem1_csr_addr == A_MCAUSE)
        mcause <= wdata[31] ? {wdata[31], 26'b0, wdata[4:0]}
                            : {28'b0, wdata[3:0]};
      else if (trap)
        mcause <= {28'b0, wb_exc_cause};

      if (wen && mem1_csr_addr == A_MTVAL)
        mtval <= wdata;
      else if (trap)
        mtval <= trap_tval;
    end
  end

endmodule

// File: tb/tb_unique0_csr.sv
// Bench for unique0_csr: directed vector table, counter sequence, then random
// traffic checked against a register-level reference model.
module tb_unique0_csr;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic [11:0] mem1_csr_addr;
  logic [1:0]  mem1_csr_write;
  logic [31:0] mem1_csr_din;
  logic        csr_error, csr_flush;
  logic [31:0] csr_dout;
  logic        wb_valid, wb_stall, wb_exc, wb_flush;
  logic [3:0]  wb_exc_cause;
  logic [29:0] wb_pc;
  logic [31:0] wb_data;
  logic        csr_kill, csr_fe_inhibit, csr_setpc;
  logic [29:0] csr_newpc;
  logic [31:0] csr_satp;

  int total = 0;
  int bad   = 0;

  always #5 clk_core = ~clk_core;

  unique0_csr dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .mem1_csr_addr(mem1_csr_addr), .mem1_csr_write(mem1_csr_write), .mem1_csr_din(mem1_csr_din),
    .csr_error(csr_error), .csr_flush(csr_flush), .csr_dout(csr_dout),
    .wb_valid(wb_valid), .wb_stall(wb_stall), .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
    .wb_flush(wb_flush), .wb_pc(wb_pc), .wb_data(wb_data),
    .csr_kill(csr_kill), .csr_fe_inhibit(csr_fe_inhibit), .csr_setpc(csr_setpc),
    .csr_newpc(csr_newpc), .csr_satp(csr_satp)
  );

  // Reference model state, byte-addressed where the architecture is.
  logic [31:0]     m_satp, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  bit              m_mie, m_mpie;
  longint unsigned m_cycle, m_instret;

  task automatic m_reset();
    m_satp = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_mie = 0; m_mpie = 0; m_cycle = 0; m_instret = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit unimp);
    unimp = 0;
    case (a)
      12'h180: return m_satp;
      12'h300: return 32'h1800 + (m_mie ? 32'h8 : 0) + (m_mpie ? 32'h80 : 0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hC00, 12'hC01: return 32'(m_cycle);
      12'hC02: return 32'(m_instret);
      12'hC80, 12'hC81: return 32'(m_cycle >> 32);
      12'hC82: return 32'(m_instret >> 32);
      default: begin unimp = 1; return 0; end
    endcase
  endfunction

  function automatic logic [31:0] m_wdata();
    bit u;
    logic [31:0] cur;
    cur = m_read(mem1_csr_addr, u);
    case (mem1_csr_write)
      2'd2:    return cur | mem1_csr_din;
      2'd3:    return cur & ~mem1_csr_din;
      default: return mem1_csr_din;
    endcase
  endfunction

  // Applies one rising edge's worth of architectural effects using the current inputs.
  task automatic m_step();
    bit wen, trap, eret;
    logic [31:0] wd;
    int c;
    wen  = (mem1_csr_write != 0);
    wd   = m_wdata();
    c    = int'(wb_exc_cause);
    trap = wb_exc && c != 10;
    eret = wb_exc && c == 10;
    if (wen && mem1_csr_addr == 12'h180) m_satp = wd;
    if (wen && mem1_csr_addr == 12'h300) begin
      m_mie = wd[3]; m_mpie = wd[7];
    end else if (trap) begin
      m_mpie = m_mie; m_mie = 0;
    end else if (eret) begin
      m_mie = m_mpie; m_mpie = 1;
    end
    if (wen && mem1_csr_addr == 12'h305) m_mtvec = wd & ~32'h2;
    if (wen && mem1_csr_addr == 12'h340) m_mscratch = wd;
    if (wen && mem1_csr_addr == 12'h341) m_mepc = wd & ~32'h3;
    else if (trap) m_mepc = {wb_pc, 2'b00};
    if (wen && mem1_csr_addr == 12'h342)
      m_mcause = wd[31] ? (wd & 32'h8000001F) : (wd & 32'hF);
    else if (trap) m_mcause = 32'(c);
    if (wen && mem1_csr_addr == 12'h343) m_mtval = wd;
    else if (trap) begin
      if (c inside {0, 1, 3, 12})              m_mtval = {wb_pc, 2'b00};
      else if (c inside {2, 4, 5, 6, 7, 13, 15}) m_mtval = wb_data;
      else                                     m_mtval = 0;
    end
    m_cycle++;
    if (wb_valid && !wb_stall) m_instret++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    if (reset_n) m_step(); else m_reset();
    #1;
  endtask

  task automatic idle();
    mem1_csr_addr = 0; mem1_csr_write = 0; mem1_csr_din = 0;
    wb_valid = 0; wb_stall = 0; wb_exc = 0; wb_exc_cause = 0;
    wb_flush = 0; wb_pc = 0; wb_data = 0;
  endtask

  typedef struct {
    logic [11:0] addr; logic [1:0] op; logic [31:0] din;
    logic exc; logic [3:0] cause; logic [29:0] pc; logic [31:0] data;
    logic valid, stall, flush;
    logic chk_dout; logic [31:0] dout; logic err, flsh, kill, setpc;
    logic [29:0] newpc; logic [31:0] satp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [11:0] addr, logic [1:0] op, logic [31:0] din,
      logic exc, logic [3:0] cause, logic [29:0] pc, logic [31:0] data,
      logic valid, logic stall, logic flush, logic chk_dout, logic [31:0] dout,
      logic err, logic flsh, logic kill, logic setpc, logic [29:0] newpc, logic [31:0] satp);
    vec_t v;
    v.addr = addr; v.op = op; v.din = din; v.exc = exc; v.cause = cause; v.pc = pc;
    v.data = data; v.valid = valid; v.stall = stall; v.flush = flush;
    v.chk_dout = chk_dout; v.dout = dout; v.err = err; v.flsh = flsh; v.kill = kill;
    v.setpc = setpc; v.newpc = newpc; v.satp = satp;
    return v;
  endfunction

  task automatic check_model(input string tag);
    bit u, trap, eret;
    logic [31:0] ed;
    logic [29:0] np;
    ed   = m_read(mem1_csr_addr, u);
    trap = wb_exc && wb_exc_cause != 4'd10;
    eret = wb_exc && wb_exc_cause == 4'd10;
    np   = trap ? m_mtvec[31:2] : (eret ? m_mepc[31:2] : wb_pc);
    chk({tag, "_dout"}, csr_dout, ed);
    chk({tag, "_err"}, csr_error, u || (mem1_csr_write != 0 && (mem1_csr_addr >> 10) == 3));
    chk({tag, "_flush"}, csr_flush, mem1_csr_write != 0 && mem1_csr_addr == 12'h180);
    chk({tag, "_kill"}, csr_kill, wb_exc || (wb_valid && wb_flush));
    chk({tag, "_inhibit"}, csr_fe_inhibit, wb_stall);
    chk({tag, "_setpc"}, csr_setpc, wb_exc || wb_stall);
    chk({tag, "_newpc"}, csr_newpc, np);
    chk({tag, "_satp"}, csr_satp, m_satp);
  endtask

  initial begin
    logic [31:0] a0, a1, c0, c1;
    logic [11:0] addrs [13];

    vecs.push_back(mk(12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1800, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h180, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h7C0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h340, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h340, 2, 32'h0F0F0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h340, 3, 32'h000000FF, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAFAFA5A5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h340, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAFAFA500, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(12'h180, 1, 32'h80001234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(12'h305, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1800, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 1, 2, 30'h40, 32'hDEADBEEF, 0, 0, 0, 1, 32'h1808, 0, 0, 1, 1, 30'h40, 32'h80001234));
    vecs.push_back(mk(12'h341, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h343, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 1, 10, 0, 0, 0, 0, 0, 1, 32'h1880, 0, 0, 1, 1, 30'h40, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1888, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'hC00, 1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h342, 1, 32'h8000001F, 1, 5, 30'h10, 32'h1234, 0, 0, 0, 1, 32'h2, 0, 0, 1, 1, 30'h40, 32'h80001234));
    vecs.push_back(mk(12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000001F, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h341, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h343, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1880, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h342, 1, 32'h3F, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000001F, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h342, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hF, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h305, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h305, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFD, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 0, 0, 30'h3FFFFFFF, 0, 1, 0, 1, 1, 32'h1880, 0, 0, 1, 0, 30'h3FFFFFFF, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 0, 0, 30'h123, 0, 1, 1, 0, 1, 32'h1880, 0, 0, 0, 1, 30'h123, 32'h80001234));
    vecs.push_back(mk(12'hC82, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'hC02, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 1, 32'h88, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1880, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h300, 3, 32'h80, 1, 8, 30'h20, 32'h55, 0, 0, 0, 1, 32'h1888, 0, 0, 1, 1, 30'h3FFFFFFF, 32'h80001234));
    vecs.push_back(mk(12'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1808, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h343, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h80001234));
    vecs.push_back(mk(12'h341, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0, 32'h80001234));

    idle();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;

    foreach (vecs[i]) begin
      mem1_csr_addr = vecs[i].addr; mem1_csr_write = vecs[i].op; mem1_csr_din = vecs[i].din;
      wb_exc = vecs[i].exc; wb_exc_cause = vecs[i].cause; wb_pc = vecs[i].pc;
      wb_data = vecs[i].data; wb_valid = vecs[i].valid; wb_stall = vecs[i].stall;
      wb_flush = vecs[i].flush;
      #4;
      if (vecs[i].chk_dout) chk($sformatf("v%0d_dout", i), csr_dout, vecs[i].dout);
      chk($sformatf("v%0d_err", i), csr_error, vecs[i].err);
      chk($sformatf("v%0d_flush", i), csr_flush, vecs[i].flsh);
      chk($sformatf("v%0d_kill", i), csr_kill, vecs[i].kill);
      chk($sformatf("v%0d_setpc", i), csr_setpc, vecs[i].setpc);
      chk($sformatf("v%0d_newpc", i), csr_newpc, vecs[i].newpc);
      chk($sformatf("v%0d_satp", i), csr_satp, vecs[i].satp);
      chk($sformatf("v%0d_inhibit", i), csr_fe_inhibit, vecs[i].stall);
      tick();
    end

    // Counter deltas: 3 valid cycles with one stalled, and a rejected write to cycle.
    idle(); mem1_csr_addr = 12'hC02; #4; a0 = csr_dout; tick();
    mem1_csr_addr = 12'hC00; mem1_csr_write = 2'd1; wb_valid = 1; #4; c0 = csr_dout;
    chk("cnt_wr_err", csr_error, 1'b1); tick();
    mem1_csr_write = 0; mem1_csr_addr = 12'h300; wb_stall = 1; tick();
    wb_stall = 0; tick();
    wb_valid = 0; mem1_csr_addr = 12'hC00; #4; c1 = csr_dout; tick();
    mem1_csr_addr = 12'hC02; #4; a1 = csr_dout;
    chk("instret_delta", a1 - a0, 2);
    chk("cycle_delta", c1 - c0, 3);
    check_model("cnt_model");
    tick();

    addrs = '{12'h180, 12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    for (int n = 0; n < 400; n++) begin
      mem1_csr_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 12)];
      mem1_csr_write = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
      mem1_csr_din   = $urandom;
      wb_exc         = ($urandom_range(0, 3) == 0);
      wb_exc_cause   = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom);
      wb_valid       = 1'($urandom);
      wb_stall       = ($urandom_range(0, 3) == 0);
      wb_flush       = 1'($urandom);
      wb_pc          = 30'($urandom);
      wb_data        = $urandom;
      #4;
      check_model($sformatf("r%0d", n));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unique0_csr.md
UNIQUE0_CSR -- requirements
Module: unique0_csr

Interface
REQ-001 clk_core  input  1  core clock; all state updates occur on its rising edge.
REQ-002 reset_n  input  1  reset, synchronous, active-low.
REQ-003 mem1_csr_addr  input  12  CSR address, used for both read and write.
REQ-004 mem1_csr_write  input  2  write op: 00 none, 01 write, 10 set, 11 clear.
REQ-005 mem1_csr_din  input  32  write operand.
REQ-006 csr_error  output  1  access to an unimplemented CSR, or a write to a read-only CSR.
REQ-007 csr_flush  output  1  pipeline flush request caused by a satp write.
REQ-008 csr_dout  output  32  combinational read data.
REQ-009 wb_valid  input  1  writeback stage holds a valid instruction.
REQ-010 wb_stall  input  1  writeback stage is stalled.
REQ-011 wb_exc  input  1  trap or ERET is taken in writeback.
REQ-012 wb_exc_cause  input  4  cause code: IALIGN=0, IFAULT=1, IILLEGAL=2, EBREAK=3, LALIGN=4, LFAULT=5, SALIGN=6, SFAULT=7, UCALL=8, SCALL=9, ERET=10, MCALL=11, IPFAULT=12, LPFAULT=13, SPFAULT=15.
REQ-013 wb_flush  input  1  writeback instruction requests a flush.
REQ-014 wb_pc  input  30  writeback PC, bits [31:2].
REQ-015 wb_data  input  32  faulting instruction or fault address for mtval.
REQ-016 csr_kill  output  1  kill in-flight instructions.
REQ-017 csr_fe_inhibit  output  1  inhibit fetch.
REQ-018 csr_setpc  output  1  redirect fetch to csr_newpc.
REQ-019 csr_newpc  output  30  redirect target, bits [31:2].
REQ-020 csr_satp  output  32  current satp value.

Function
REQ-021 The write enable wen SHALL be (mem1_csr_write != 00); wdata SHALL be din for op 01, csr_dout|din for op 10, and csr_dout&~din for op 11; the addressed CSR SHALL update at the next edge.
REQ-022 csr_dout SHALL be a combinational mux: 0x180 satp, 0x300 mstatus, 0x305 mtvec, 0x340 mscratch, 0x341 {mepc,2'b00}, 0x342 mcause, 0x343 mtval, 0xC00/0xC01 cycle[31:0], 0xC02 instret[31:0], 0xC80/0xC81 cycle[63:32], 0xC82 instret[63:32]; any other address SHALL read 0 and flag unimp.
REQ-023 csr_error SHALL equal unimp | (wen & addr[11] & addr[10]); counters SHALL never be written.
REQ-024 satp SHALL be a 32-bit read/write register; csr_flush SHALL equal wen & (addr==0x180); csr_satp SHALL equal satp.
REQ-025 cycle SHALL be a 64-bit counter that increments every clock; instret SHALL be a 64-bit counter that increments when wb_valid & ~wb_stall; both SHALL wrap modulo 2^64.
REQ-026 mstatus: only bit 3 (MIE) and bit 7 (MPIE) SHALL be writable; bits 12:11 SHALL read 11; all other bits SHALL read 0.
REQ-027 A trap is wb_exc & cause!=ERET; on a trap MIE<=0 and MPIE<=MIE; on wb_exc with ERET, MIE<=MPIE and MPIE<=1.
REQ-028 mtvec: bits 31:2 and bit 0 SHALL be writable; bit 1 SHALL read 0.
REQ-029 mscratch SHALL be a 32-bit read/write register.
REQ-030 mepc SHALL store bits 31:2 and read with bits 1:0 = 0; a trap SHALL load wb_pc into mepc.
REQ-031 mcause write: bit 31 SHALL take wdata[31]; when wdata[31]=1, bits 4:0 SHALL take wdata[4:0], otherwise bits 3:0 SHALL take wdata[3:0]; all other bits SHALL be 0; a trap SHALL load {28'b0, cause}.
REQ-032 mtval: a trap SHALL load {wb_pc,2'b00} for IALIGN/IFAULT/IPFAULT/EBREAK, wb_data for IILLEGAL/L*/S* causes, and 0 otherwise.
REQ-033 For every CSR, a software write in the same cycle as a trap or ERET SHALL take priority; the other trap side effects on that CSR SHALL be lost.
REQ-034 csr_kill SHALL equal wb_exc | (wb_valid & wb_flush); csr_fe_inhibit SHALL equal wb_stall; csr_setpc SHALL equal wb_exc | wb_stall.
REQ-035 csr_newpc SHALL be mtvec[31:2] on a trap, mepc on wb_exc with ERET, and wb_pc otherwise; mtvec mode is ignored for redirection.

Reset
REQ-036 On reset_n=0 at a clock edge, every register SHALL clear to 0, except mstatus, which SHALL reset to 0x00001800.

Verification
REQ-037 Reset, then read 0x300 -> 0x00001800; read 0x180 -> 0; read 0x7C0 -> dout=0 and csr_error=1.
REQ-038 Write 0x340=0xA5A5A5A5, set 0x0F0F0000, clear 0x000000FF -> mscratch reads 0xAFAFA500.
REQ-039 Write 0x180=0x80001234 -> csr_flush=1 in that cycle; csr_satp=0x80001234 after the edge.
REQ-040 With mtvec=0x100, MIE=1, trap with cause=2, wb_pc=0x40 (byte 0x100), wb_data=0xDEADBEEF -> csr_newpc=0x40, csr_setpc=1, csr_kill=1; afterwards mepc=0x100, mcause=2, mtval=0xDEADBEEF, MIE=0, MPIE=1.
REQ-041 Follow REQ-040 with an ERET -> csr_newpc = mepc[31:2]; afterwards MIE=1, MPIE=1, and mcause unchanged.
REQ-042 Hold wb_valid=1 for 3 cycles with 1 stall cycle -> instret increases by 2 while cycle increases by 3; a write to 0xC00 raises csr_error=1.
